// File: rtl/orx_pkg.sv
// Shared encodings and elaboration helpers for the orx reduction-tree cells.
package orx_pkg;

    localparam logic [1:0] ORX_MODE_OR  = 2'b00;
    localparam logic [1:0] ORX_MODE_AND = 2'b01;
    localparam logic [1:0] ORX_MODE_XOR = 2'b10;

    // Neutral element of the selected reduction; reserved mode behaves as OR.
    function automatic logic orx_identity(input logic [1:0] mode);
        return (mode == ORX_MODE_AND);
    endfunction

    function automatic int unsigned orx_clog(input int unsigned size, input int unsigned radix);
        int unsigned span;
        int unsigned lv;
        span = 1;
        lv   = 0;
        while (span < size) begin
            span = span * radix;
            lv++;
        end
        return lv;
    endfunction

    function automatic int unsigned orx_levels(input int unsigned size, input int unsigned radix);
        int unsigned lv;
        lv = orx_clog(size, radix);
        return (lv == 0) ? 1 : lv;
    endfunction

    function automatic int unsigned orx_pow(input int unsigned base, input int unsigned ex);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < ex; i++) begin
            r = r * base;
        end
        return r;
    endfunction

endpackage

// File: rtl/orx_node_gea1.sv
// One RADIX-input combinational tree node; reduces its inputs with the selected operator.
module orx_node_gea1 #(
    parameter int unsigned RADIX = 4
) (
    input  logic [RADIX-1:0] d_i,
    input  logic [1:0]       mode_i,
    output logic             y_o
);
    import orx_pkg::*;

    always_comb begin
        y_o = |d_i;
        case (mode_i)
            ORX_MODE_AND: y_o = &d_i;
            ORX_MODE_XOR: y_o = ^d_i;
            default:      y_o = |d_i;
        endcase
    end

endmodule

// File: rtl/orx_tree_gea1.sv
// Pipelined OR/AND/XOR reduction tree with per-bit enables, valid tagging and a sticky flag.
module orx_tree_gea1 #(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned RADIX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_vld,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] en,
    input  logic [1:0]      mode,
    input  logic            clr,
    output logic            y,
    output logic            out_vld,
    output logic            y_sticky
);
    import orx_pkg::*;

    localparam int unsigned Levels = orx_levels(SIZE, RADIX);
    // Leaves are padded up to a full tree so every node sees exactly RADIX inputs.
    localparam int unsigned Leaves = orx_pow(RADIX, Levels);

    logic [Leaves-1:0] leaf;
    logic              sticky_q, sticky_d;
    logic              sticky_set;

    always_comb begin
        leaf = {Leaves{orx_identity(mode)}};
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (en[i]) begin
                leaf[i] = a[i];
            end
        end
    end

    for (genvar l = 0; l < Levels; l++) begin : g_lvl
        localparam int unsigned NIn  = orx_pow(RADIX, Levels - l);
        localparam int unsigned NOut = NIn / RADIX;

        logic [NIn-1:0]  din;
        logic [1:0]      mode_in;
        logic            vld_in;
        logic [NOut-1:0] dnode;
        logic [NOut-1:0] dat_q;
        logic            vld_q;

        if (l == 0) begin : g_src
            assign din     = leaf;
            assign mode_in = mode;
            assign vld_in  = in_vld;
        end else begin : g_chain
            assign din     = g_lvl[l-1].dat_q;
            assign mode_in = g_lvl[l-1].g_mreg.mode_q;
            assign vld_in  = g_lvl[l-1].vld_q;
        end

        for (genvar n = 0; n < NOut; n++) begin : g_node
            orx_node_gea1 #(
                .RADIX(RADIX)
            ) u_node (
                .d_i   (din[n*RADIX +: RADIX]),
                .mode_i(mode_in),
                .y_o   (dnode[n])
            );
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dat_q <= '0;
                vld_q <= 1'b0;
            end else begin
                vld_q <= vld_in;
                if (vld_in) begin
                    dat_q <= dnode;
                end
            end
        end

        // The final level has no consumer for the mode, so it carries none.
        if (l < Levels - 1) begin : g_mreg
            logic [1:0] mode_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mode_q <= ORX_MODE_OR;
                end else if (vld_in) begin
                    mode_q <= mode_in;
                end
            end
        end
    end

    assign y       = g_lvl[Levels-1].dat_q[0];
    assign out_vld = g_lvl[Levels-1].vld_q;

    // Set term uses the values landing in y/out_vld on this same edge.
    assign sticky_set = g_lvl[Levels-1].vld_in & g_lvl[Levels-1].dnode[0];

    always_comb begin
        sticky_d = (sticky_q & ~clr) | sticky_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign y_sticky = sticky_q;

endmodule

// File: doc/orx_tree_gea1.md
# orx_tree_gea1

Parametrised, pipelined reduction tree: next generation of the generic OR-reduce cell. Reduces a SIZE-bit vector with OR, AND or XOR, selected per sample. Per-bit enable masking, a valid-tagged pipeline with one register per tree level, and a sticky event flag with clear. Sits in the generic-cells library; used for wide interrupt/status aggregation where a flat reduce misses timing.

## Interface
- SIZE, 16, input vector width (>=1)
- RADIX, 4, fan-in per tree node (2..8)
- LEVELS, derived (not overridable), max(1, ceil(log_RADIX(SIZE)))
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_vld  in  1  sample valid
- a  in  SIZE  input vector
- en  in  SIZE  per-bit enable; 0 forces the bit to the mode identity
- mode  in  2  00=OR, 01=AND, 10=XOR, 11=reserved (treated as OR)
- clr  in  1  synchronous clear of y_sticky
- y  out  1  reduction result
- out_vld  out  1  y is valid
- y_sticky  out  1  set when a valid result is 1; held until clr

One clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- Masking: bit i enters the tree as a[i] when en[i]=1, else identity (0 for OR/XOR, 1 for AND).
- Tree: LEVELS levels of RADIX-input nodes; missing leaves at the top of the last group padded with identity. Every level ends in a register.
- mode, in_vld travel alongside data through the pipeline; each level uses the mode of the sample it carries. Mode changes between consecutive samples are legal, no bubble.
- No backpressure: a new sample accepted every cycle.
- Data registers update only when the carried valid is 1 (clock-enable on in_vld per stage); valid registers update every cycle.
- y holds the last valid result while out_vld=0.
- y_sticky next = (y_sticky & ~clr) | (out_vld_next & y_next), where the _next terms are the values y and out_vld take on the same edge. Set beats clr on the same edge: an event is never lost.
- All-masked input: OR/XOR -> 0, AND -> 1.
- SIZE=1: single level, y = registered masked a[0] (XOR/OR = a&en, AND = a|~en).

## Timing
- Reset (rst_n=0, async): y=0, out_vld=0, y_sticky=0, all internal valid and data stages 0. Release synchronous to clk; first sample accepted on the first edge with rst_n=1.
- Latency: sample presented at edge N with in_vld=1 appears at out_vld=1/y after edge N+LEVELS-1 is complete (i.e. visible in cycle N+LEVELS). SIZE=16,RADIX=4: 2 cycles; SIZE=64,RADIX=4: 3.
- Throughput: 1 sample/cycle.
- clr: takes effect on the edge where it is sampled; y_sticky low the following cycle unless set on that edge.
- Reset mid-operation discards all in-flight samples; no out_vld pulses after release until new samples traverse.

## Structure
- Shared package orx_pkg: mode encodings (ORX_MODE_OR/AND/XOR), identity function orx_identity(mode), clog function for LEVELS.
- Sub-module orx_node_gea1: one RADIX-input combinational node (mode-selected reduce); top generates LEVELS rows of nodes plus per-level data/mode/valid registers.

## Test plan
- Reset: assert rst_n=0 mid-stream with samples in flight -> y=0, out_vld=0, y_sticky=0 immediately; no stale out_vld after release.
- OR, SIZE=16: a=16'h0040, en=16'hFFFF, in_vld=1 one cycle -> out_vld=1, y=1 exactly 2 cycles later; y_sticky=1 same cycle and stays after.
- Masking: a=16'h0040, en=16'hFFBF, OR -> y=0; AND with a=16'hFFBF, en=16'hFFBF -> y=1; en=0 AND -> y=1.
- Back-to-back modes: consecutive cycles OR(a=1), AND(a=16'hFFFE), XOR(a=16'h0007) -> y sequence 1,0,1 on consecutive out_vld cycles.
- Sticky vs clr: clr=1 on the edge a valid 1 result lands -> y_sticky stays 1; clr with result 0 -> y_sticky 0 next cycle.
- Geometry: SIZE=1, SIZE=5/RADIX=2 (LEVELS=3, padding), SIZE=64/RADIX=4 -> latency = LEVELS, random vectors match reference model.
